// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, FIFO control states and link timing constants.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_ACTIVE,
        FIFO_FULL
    } fifo_state_t;

    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 115200;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between UART RX strobes and the valid/ready UART TX,
// with sticky overflow flag and saturating drop counter for debug display.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       drop_count,
    input  logic              clear
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    byte_t             mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    fifo_state_t       state_q, state_d;

    logic do_push;
    logic do_pop;
    logic do_drop;

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level      = level_q;
    assign full       = (state_q == FIFO_FULL);
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    // A full FIFO drops the incoming byte even when a pop frees a slot in the same cycle.
    assign do_push = in_valid && !full && !clear;
    assign do_drop = in_valid &&  full && !clear;
    assign do_pop  = out_valid && out_ready && !clear;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        state_d    = state_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        case (state_q)
            FIFO_EMPTY:  if (do_push) state_d = FIFO_ACTIVE;
            FIFO_ACTIVE: begin
                if (level_d == LEVEL_FULL)  state_d = FIFO_FULL;
                else if (level_d == '0)     state_d = FIFO_EMPTY;
            end
            FIFO_FULL:   if (do_pop) state_d = FIFO_ACTIVE;
            default:     state_d = FIFO_EMPTY;
        endcase
        if (clear) state_d = FIFO_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= FIFO_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    // NOTE: storage is deliberately unreset; out_data is masked while empty so stale words never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven vectors plus scoreboard-checked sequences.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb[$];
    logic [15:0] m_drops = 16'd0;
    logic        m_ovf   = 1'b0;
    logic        last_pop_valid;
    logic [7:0]  last_pop_data;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_level;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic rdy, input logic clr);
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
        clear     = clr;
    endtask

    // Advances one clock; the reference model updates from the inputs present before the edge.
    task automatic tick();
        logic       pop_m, push_m, drop_m;
        logic [7:0] exp_b;
        pop_m  = (sb.size() != 0) && out_ready && !clear;
        push_m = in_valid && !clear && (sb.size() < DEPTH);
        drop_m = in_valid && !clear && (sb.size() >= DEPTH);
        last_pop_valid = pop_m;
        last_pop_data  = out_data;
        if (pop_m) begin
            exp_b = sb.pop_front();
            check("pop_data", out_data, exp_b);
        end
        if (clear) begin
            sb.delete();
            m_drops = 16'd0;
            m_ovf   = 1'b0;
        end
        if (push_m) sb.push_back(in_data);
        if (drop_m) begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        @(posedge clk);
        #1;
        check("level",      level,      sb.size());
        check("out_valid",  out_valid,  sb.size() != 0);
        check("full",       full,       sb.size() == DEPTH);
        check("out_data",   out_data,   (sb.size() != 0) ? sb[0] : 8'h00);
        check("overflow",   overflow,   m_ovf);
        check("drop_count", drop_count, m_drops);
    endtask

    task automatic add_vec(input logic iv, input logic [7:0] id, input logic rdy, input logic clr,
                           input logic ev, input logic [7:0] ed, input logic [4:0] el, input logic ef);
        vec_t v;
        v.iv = iv; v.id = id; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_full = ef;
        vecs.push_back(v);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", level, 0);
    endtask

    initial begin
        // Spec test 1: single byte falls through, then holds for 10 cycles.
        add_vec(1, 8'h41, 0, 0,  1, 8'h41, 1, 0);
        for (int i = 0; i < 10; i++) add_vec(0, 8'h00, 0, 0,  1, 8'h41, 1, 0);
        // Spec test 2: ordered push of 01..05 then ordered drain.
        add_vec(0, 8'h00, 0, 1,  0, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) add_vec(1, 8'(i), 0, 0,  1, 8'h01, 5'(i), 0);
        for (int i = 1; i <= 4; i++) add_vec(0, 8'h00, 1, 0,  1, 8'(i + 1), 5'(5 - i), 0);
        add_vec(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_level",  level,      0);
        check("rst_valid",  out_valid,  0);
        check("rst_data",   out_data,   8'h00);
        check("rst_full",   full,       0);
        check("rst_ovf",    overflow,   0);
        check("rst_drops",  drop_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].rdy, vecs[i].clr);
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_data",  i), out_data,  vecs[i].e_data);
            check($sformatf("vec%0d_level", i), level,     vecs[i].e_level);
            check($sformatf("vec%0d_full",  i), full,      vecs[i].e_full);
        end

        // Spec test 3: 17 pushes into 16 entries.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        check("t3_full",  full,       1);
        check("t3_level", level,      16);
        check("t3_ovf",   overflow,   1);
        check("t3_drops", drop_count, 1);

        // Spec test 4: push while full with a concurrent pop is dropped.
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        tick();
        check("t4_level", level,      15);
        check("t4_drops", drop_count, 2);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            tick();
            check("t4_no_aa", last_pop_valid && last_pop_data == 8'hAA, 0);
        end
        check("t4_empty", out_valid, 0);

        // Spec test 5: clear beats push and pop in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        check("t5_level3", level, 3);
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        tick();
        check("t5_level", level,      0);
        check("t5_valid", out_valid,  0);
        check("t5_drops", drop_count, 0);
        check("t5_ovf",   overflow,   0);

        // Spec test 6: asynchronous reset mid-stream.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            tick();
        end
        check("t6_level7", level, 7);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", level,     0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data",  out_data,  8'h00);
        check("t6_rst_full",  full,      0);
        sb.delete();
        m_drops = 16'd0;
        m_ovf   = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        check("t6_5a", out_data, 8'h5A);
        drain(4);

        // Pointer wrap: 40 bytes through with random back-pressure.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
